// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Round-robin arbiter that funnels NrPorts requesters into one data-cache
//   request port through a single registered output slot, and routes in-order
//   cache responses back to the requester that issued them.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   flush_i / flush_ack_o     drain request (level) / drain complete
//   port_req_*_i              per-port request valid + payload
//   port_req_ready_o          one-hot capture strobe (at most one bit)
//   port_rsp_valid_o          one-hot response strobe (at most one bit)
//   port_rsp_rdata_o          response data, shared by all ports
//   cache_req_*               registered request to cache (valid/ready)
//   cache_rsp_valid_i/rdata_i in-order response from cache
//   outstanding_o             requests accepted by cache, not yet answered
//   err_o                     sticky: response arrived with nothing outstanding
module dcache_port_arbiter #(
  parameter int NrPorts        = 3,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 7
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  output logic                                flush_ack_o,
  input  logic [NrPorts-1:0]                  port_req_valid_i,
  output logic [NrPorts-1:0]                  port_req_ready_o,
  input  logic [NrPorts-1:0][AddrWidth-1:0]   port_req_addr_i,
  input  logic [NrPorts-1:0]                  port_req_we_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]   port_req_wdata_i,
  input  logic [NrPorts-1:0][DataWidth/8-1:0] port_req_be_i,
  output logic [NrPorts-1:0]                  port_rsp_valid_o,
  output logic [DataWidth-1:0]                port_rsp_rdata_o,
  output logic                                cache_req_valid_o,
  input  logic                                cache_req_ready_i,
  output logic [AddrWidth-1:0]                cache_req_addr_o,
  output logic                                cache_req_we_o,
  output logic [DataWidth-1:0]                cache_req_wdata_o,
  output logic [DataWidth/8-1:0]              cache_req_be_o,
  input  logic                                cache_rsp_valid_i,
  input  logic [DataWidth-1:0]                cache_rsp_rdata_i,
  output logic [3:0]                          outstanding_o,
  output logic                                err_o
);

  localparam int PortW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int FifoW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int BeW   = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // FIFO pointers wrap at the configured depth, which need not be a power of 2.
  function automatic logic [FifoW-1:0] fifo_ptr_inc(input logic [FifoW-1:0] p);
    return (p == FifoW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic               slot_full_q, slot_full_d;
  logic [PortW-1:0]   ptr_q;
  logic [3:0]         cnt_q;
  logic               err_q;
  logic [FifoW-1:0]   wr_ptr_q, rd_ptr_q;

  logic [AddrWidth-1:0] slot_addr;
  logic                 slot_we;
  logic [DataWidth-1:0] slot_wdata;
  logic [BeW-1:0]       slot_be;
  logic [PortW-1:0]     slot_id;
  logic [PortW-1:0]     id_fifo [MaxOutstanding];

  logic             handoff, pop, cap_allowed, capture, grant_found, drain_done;
  logic [PortW-1:0] grant_idx, head_id;

  assign handoff    = slot_full_q && cache_req_ready_i;
  // A response with nothing outstanding is a protocol error and is dropped.
  assign pop        = cache_rsp_valid_i && (cnt_q != 4'd0);
  assign head_id    = id_fifo[rd_ptr_q];
  assign drain_done = (state_q == DRAIN) && !slot_full_q && (cnt_q == 4'd0);

  // Round-robin search starting at ptr_q, wrapping around the port list.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NrPorts; i++) begin
      cand = (int'(ptr_q) + i) % NrPorts;
      if (!grant_found && port_req_valid_i[PortW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PortW'(cand);
      end
    end
  end

  // After a handoff the counter grows by one and the slot empties, so
  // (outstanding + occupancy) after handoff is simply cnt_q + slot_full_q.
  // Keeping that below the limit guarantees the slot can always hand off.
  assign cap_allowed = !rst_i && (state_q != DRAIN) && !flush_i &&
                       (!slot_full_q || handoff) &&
                       (({1'b0, cnt_q} + {4'd0, slot_full_q}) < 5'(MaxOutstanding));
  assign capture     = cap_allowed && grant_found;

  assign slot_full_d = capture ? 1'b1 : (handoff ? 1'b0 : slot_full_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BUSY: begin
        if (flush_i) state_d = DRAIN;
        else         state_d = slot_full_d ? BUSY : IDLE;
      end
      DRAIN: begin
        if (drain_done && !flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      slot_full_q <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      if (capture)
        ptr_q <= (grant_idx == PortW'(NrPorts - 1)) ? '0 : grant_idx + 1'b1;
      if (handoff && !pop)      cnt_q <= cnt_q + 4'd1;
      else if (pop && !handoff) cnt_q <= cnt_q - 4'd1;
      if (handoff) wr_ptr_q <= fifo_ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= fifo_ptr_inc(rd_ptr_q);
      if (cache_rsp_valid_i && (cnt_q == 4'd0)) err_q <= 1'b1;
    end
  end

  // Slot payload and ID storage
  always_ff @(posedge clk_i) begin
    if (capture) begin
      slot_addr  <= port_req_addr_i[grant_idx];
      slot_we    <= port_req_we_i[grant_idx];
      slot_wdata <= port_req_wdata_i[grant_idx];
      slot_be    <= port_req_be_i[grant_idx];
      slot_id    <= grant_idx;
    end
    if (handoff) id_fifo[wr_ptr_q] <= slot_id;
  end

  assign port_req_ready_o  = capture ? (NrPorts'(1) << grant_idx) : '0;
  assign port_rsp_valid_o  = (pop && !rst_i) ? (NrPorts'(1) << head_id) : '0;
  assign port_rsp_rdata_o  = cache_rsp_rdata_i;
  assign cache_req_valid_o = slot_full_q;
  assign cache_req_addr_o  = slot_addr;
  assign cache_req_we_o    = slot_we;
  assign cache_req_wdata_o = slot_wdata;
  assign cache_req_be_o    = slot_be;
  assign outstanding_o     = cnt_q;
  assign err_o             = err_q;
  assign flush_ack_o       = drain_done && !rst_i;

endmodule
